// File: rtl/wb_addsub_initiator.sv
// ---------------------------------------------------------------------------
// wb_addsub_initiator
//
// Wishbone classic-cycle initiator for the add/sub responder. It accepts one
// command at a time from a local sequencer. A command is a write of the packed
// operands {a,b}, a read of the result, or both in that order. The command
// finishes by presenting a response. The read data, or 0 when there is no read,
// is held until the sequencer consumes it.
//
// Optional feature: define WB_ADDSUB_INITIATOR_TIMEOUT_EN to add a strobe
// timeout. If no ack arrives within TIMEOUT_CYCLES strobe cycles, the bus
// cycle is abandoned. The response then carries rsp_err_o=1 and 32'hDEAD_0000.
// When the macro is undefined, WR/RD wait indefinitely and rsp_err_o is 0.
//
// Parameters:
//   BASE_ADR        address driven on wbm_adr_o during every bus cycle
//   TIMEOUT_CYCLES  strobe cycles without ack before timeout (>=2, optional)
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_op_i                 00 write+read, 01 write, 10 read, 11 reserved
//   cmd_a_i, cmd_b_i         16-bit operands, written as {a,b}
//   wbm_*                    Wishbone initiator port (registered outputs)
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_data_o, rsp_err_o    captured read data, timeout flag
//   busy_o                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module wb_addsub_initiator #(
  parameter logic [31:0] BASE_ADR       = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, WR, GAP, RD, RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
  // The counter only has to reach TIMEOUT_CYCLES-1. Reaching that value
  // while the strobe is still unacknowledged is the timeout condition.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Next-state and next-output logic. The bus outputs are derived from the
  // next state, so each one is a plain register that changes with the state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d = cmd_op_i;
          a_d  = cmd_a_i;
          b_d  = cmd_b_i;
          case (cmd_op_i)
            2'b00, 2'b01: state_d = WR;
            2'b10:        state_d = RD;
            default: begin
              // A reserved op still produces a response, so the sequencer
              // never stalls waiting for it.
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = 32'h0;
            end
          endcase
        end
      end

      WR: begin
        if (wbm_ack_i) begin
          if (op_q == 2'b00) begin
            state_d = GAP;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'h0;
          end
        end
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'hDEAD_0000;
          rsp_err_d   = 1'b1;
        end
`endif
      end

      // One idle bus cycle lets the responder's registered ack fall before
      // the read strobe is raised. Otherwise the stale write ack could end
      // the read early.
      GAP: state_d = RD;

      RD: begin
        if (wbm_ack_i) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wbm_dat_i;
        end
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'hDEAD_0000;
          rsp_err_d   = 1'b1;
        end
`endif
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

    cyc_d = (state_d == WR) || (state_d == RD);
    we_d  = (state_d == WR);
    sel_d = cyc_d ? 4'hF : 4'h0;
    adr_d = cyc_d ? BASE_ADR : 32'h0;
    dat_d = we_d ? {a_d, b_d} : 32'h0;

`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
    // The counter restarts on every entry into WR or RD, and it counts
    // while the strobe stays in the same phase without an ack.
    cnt_d = (cyc_d && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      a_q         <= 16'h0;
      b_q         <= 16'h0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
  assign rsp_err_o   = rsp_err_q;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_addsub_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_addsub_initiator
//
// Self-checking bench for wb_addsub_initiator. A behavioural add/sub responder
// sits on the Wishbone side and has a programmable number of extra wait
// states. Expected responses come from a command-level model. The model
// tracks the last operands written and applies the responder's arithmetic,
// and it predicts timing from the protocol phases.
// ---------------------------------------------------------------------------
module tb_wb_addsub_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmdOp = 2'b00;
  logic [15:0] cmdA = 16'h0;
  logic [15:0] cmdB = 16'h0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, datO, datI;
  logic        ack;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspData;
  logic        rspErr;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  wb_addsub_initiator #(
    .BASE_ADR      (BASE),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmdValid),
    .cmd_ready_o(cmdReady),
    .cmd_op_i   (cmdOp),
    .cmd_a_i    (cmdA),
    .cmd_b_i    (cmdB),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (datO),
    .wbm_dat_i  (datI),
    .wbm_ack_i  (ack),
    .rsp_valid_o(rspValid),
    .rsp_ready_i(rspReady),
    .rsp_data_o (rspData),
    .rsp_err_o  (rspErr),
    .busy_o     (busy)
  );

  // Responder arithmetic: add gives the full 32-bit sum of the zero-extended
  // operands, and subtract wraps at 16 bits.
  function automatic logic [31:0] respond(input logic [15:0] x, input logic [15:0] y,
                                          input bit s);
    if (s) return {16'h0, 16'(x - y)};
    return 32'(x) + 32'(y);
  endfunction

  // Behavioural responder with a registered ack. It has extraWait additional
  // wait states, and the read data is random junk except while acking.
  logic        ackR      = 1'b0;
  logic        strayAck  = 1'b0;
  int          wcnt      = 0;
  int          extraWait = 0;
  bit          mute      = 1'b0;
  bit          subMode   = 1'b0;
  logic [15:0] regA      = 16'h0;
  logic [15:0] regB      = 16'h0;
  int          wrCount   = 0;
  int          rdCount   = 0;
  logic [31:0] lastWData = 32'h0;
  logic [31:0] junk      = 32'h5A5A_A5A5;

  assign ack  = ackR | strayAck;
  assign datI = ackR ? respond(regA, regB, subMode) : junk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ackR <= 1'b0;
      wcnt <= 0;
    end else begin
      junk <= $urandom;
      ackR <= 1'b0;
      if (cyc && stb && !ackR && !mute) begin
        if (wcnt >= extraWait) begin
          ackR <= 1'b1;
          wcnt <= 0;
          if (we) begin
            regA      <= datO[31:16];
            regB      <= datO[15:0];
            lastWData <= datO;
            wrCount   <= wrCount + 1;
          end else begin
            rdCount <= rdCount + 1;
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!(cyc && stb)) begin
        wcnt <= 0;
      end
    end
  end

  // Command-level model state: the operands the responder should hold.
  logic [15:0] modelA = 16'h0;
  logic [15:0] modelB = 16'h0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    bit          sub;
    int          extra;
    int          rspDelay;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Each bus phase lasts 2+extra cycles. A write+read adds the single gap
  // cycle, and the response appears one cycle after the last phase ends.
  function automatic int expLatency(input logic [1:0] op, input int extra);
    if (op == 2'b11) return 1;
    if (op == 2'b00) return 2 * (2 + extra) + 2;
    return (2 + extra) + 1;
  endfunction

  function automatic int expCycHigh(input logic [1:0] op, input int extra);
    if (op == 2'b11) return 0;
    if (op == 2'b00) return 2 * (2 + extra);
    return 2 + extra;
  endfunction

  // Offers a command while cmdReady is high. Returns #1 after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b);
    for (int i = 0; i < 50 && !cmdReady; i++) @(negedge clk);
    if (!cmdReady) checkOutput("cmdReady wait", {31'h0, cmdReady}, 32'h1);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdA     = a;
    cmdB     = b;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  // Counts negedges until rspValid is seen. It also tallies cycles with cyc
  // high and cycles that break the bus output rules.
  task automatic waitValid(output bit got, output int cycles, output int cycHigh,
                           output int viol);
    got = 1'b0; cycles = 0; cycHigh = 0; viol = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (cyc) cycHigh++;
      if ((stb !== cyc) ||
          (cyc && (sel !== 4'hF || adr !== BASE)) ||
          (!cyc && (sel !== 4'h0 || adr !== 32'h0 || datO !== 32'h0 || we !== 1'b0)) ||
          (cyc && !we && datO !== 32'h0))
        viol++;
      if (rspValid) begin
        got = 1'b1;
        cycles = i;
        break;
      end
    end
    if (!got) checkOutput("rspValid wait", {31'h0, rspValid}, 32'h1);
  endtask

  task automatic releaseRsp(input int rspDelay, input logic [31:0] expData,
                            input string tag);
    for (int i = 0; i < rspDelay; i++) begin
      @(negedge clk);
      checkOutput({tag, " hold valid"}, {31'h0, rspValid}, 32'h1);
      checkOutput({tag, " hold data"}, rspData, expData);
      checkOutput({tag, " hold cmdReady"}, {31'h0, cmdReady}, 32'h0);
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    @(negedge clk);
    checkOutput({tag, " after rsp valid"}, {31'h0, rspValid}, 32'h0);
    checkOutput({tag, " after rsp err"}, {31'h0, rspErr}, 32'h0);
    checkOutput({tag, " after rsp busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, " after rsp cmdReady"}, {31'h0, cmdReady}, 32'h1);
  endtask

  task automatic runCommand(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input bit sub, input int extra, input int rspDelay,
                            input logic [31:0] expData, input string tag);
    int w0, r0, cycles, cycHigh, viol;
    bit got;
    bit doesWrite, doesRead;
    doesWrite = (op == 2'b00) || (op == 2'b01);
    doesRead  = (op == 2'b00) || (op == 2'b10);
    @(negedge clk);
    subMode   = sub;
    extraWait = extra;
    w0 = wrCount;
    r0 = rdCount;
    applyStimulus(op, a, b);
    waitValid(got, cycles, cycHigh, viol);
    checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency(op, extra)));
    checkOutput({tag, " rspData"}, rspData, expData);
    checkOutput({tag, " rspErr"}, {31'h0, rspErr}, 32'h0);
    checkOutput({tag, " writes"}, 32'(wrCount - w0), doesWrite ? 32'd1 : 32'd0);
    checkOutput({tag, " reads"}, 32'(rdCount - r0), doesRead ? 32'd1 : 32'd0);
    checkOutput({tag, " cycHigh"}, 32'(cycHigh), 32'(expCycHigh(op, extra)));
    checkOutput({tag, " busRules"}, 32'(viol), 32'd0);
    if (doesWrite) checkOutput({tag, " wrData"}, lastWData, {a, b});
    releaseRsp(rspDelay, expData, tag);
    if (doesWrite) begin
      modelA = a;
      modelB = b;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cycles, cycHigh, viol, w0;
    bit got;
    logic [1:0]  rop;
    logic [15:0] ra, rb;
    bit          rsub;
    logic [31:0] rexp;

    vecs[0] = '{2'b00, 16'h0005, 16'h0003, 1'b0, 0, 0, 32'h0000_0008};
    vecs[1] = '{2'b00, 16'h0003, 16'h0005, 1'b1, 0, 1, 32'h0000_FFFE};
    vecs[2] = '{2'b01, 16'h1234, 16'h0100, 1'b0, 0, 0, 32'h0000_0000};
    vecs[3] = '{2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 32'h0000_1334};
    vecs[4] = '{2'b10, 16'h0000, 16'h0000, 1'b1, 1, 2, 32'h0000_1134};
    vecs[5] = '{2'b11, 16'h5555, 16'hAAAA, 1'b0, 0, 0, 32'h0000_0000};
    vecs[6] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 2, 0, 32'h0001_0000};
    vecs[7] = '{2'b00, 16'h0000, 16'h0001, 1'b1, 1, 3, 32'h0000_FFFF};
    vecs[8] = '{2'b10, 16'h0000, 16'h0000, 1'b0, 0, 0, 32'h0000_0001};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset cmdReady", {31'h0, cmdReady}, 32'h1);
    checkOutput("reset cyc", {31'h0, cyc}, 32'h0);
    checkOutput("reset stb", {31'h0, stb}, 32'h0);
    checkOutput("reset we", {31'h0, we}, 32'h0);
    checkOutput("reset sel", {28'h0, sel}, 32'h0);
    checkOutput("reset adr", adr, 32'h0);
    checkOutput("reset datO", datO, 32'h0);
    checkOutput("reset rspValid", {31'h0, rspValid}, 32'h0);
    checkOutput("reset rspData", rspData, 32'h0);
    checkOutput("reset rspErr", {31'h0, rspErr}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 9; i++)
      runCommand(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].extra,
                 vecs[i].rspDelay, vecs[i].expData, $sformatf("vec%0d", i));

    // Response held with a new command pending. Nothing may start until the
    // response is taken, and the pending command is accepted right after.
    @(negedge clk);
    subMode = 1'b0;
    extraWait = 0;
    applyStimulus(2'b00, 16'h0010, 16'h0020);
    waitValid(got, cycles, cycHigh, viol);
    checkOutput("hold first rspData", rspData, 32'h0000_0030);
    modelA = 16'h0010;
    modelB = 16'h0020;
    cmdValid = 1'b1;
    cmdOp = 2'b01;
    cmdA = 16'hABCD;
    cmdB = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("holdq rspValid", {31'h0, rspValid}, 32'h1);
      checkOutput("holdq rspData", rspData, 32'h0000_0030);
      checkOutput("holdq cmdReady", {31'h0, cmdReady}, 32'h0);
      checkOutput("holdq cyc", {31'h0, cyc}, 32'h0);
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1 rspReady = 1'b0;
    @(negedge clk);
    checkOutput("holdq idle rspValid", {31'h0, rspValid}, 32'h0);
    checkOutput("holdq idle cmdReady", {31'h0, cmdReady}, 32'h1);
    @(posedge clk);
    #1 cmdValid = 1'b0;
    @(negedge clk);
    checkOutput("holdq next cyc", {31'h0, cyc}, 32'h1);
    checkOutput("holdq next we", {31'h0, we}, 32'h1);
    checkOutput("holdq next datO", datO, 32'hABCD_1234);
    checkOutput("holdq next cmdReady", {31'h0, cmdReady}, 32'h0);
    waitValid(got, cycles, cycHigh, viol);
    checkOutput("holdq next rspData", rspData, 32'h0);
    releaseRsp(0, 32'h0, "holdq next");
    modelA = 16'hABCD;
    modelB = 16'h1234;

    // A stray ack in IDLE must be ignored.
    @(negedge clk);
    strayAck = 1'b1;
    @(posedge clk);
    #1 strayAck = 1'b0;
    @(negedge clk);
    checkOutput("strayAck busy", {31'h0, busy}, 32'h0);
    checkOutput("strayAck rspValid", {31'h0, rspValid}, 32'h0);
    checkOutput("strayAck cyc", {31'h0, cyc}, 32'h0);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    extraWait = 6;
    applyStimulus(2'b10, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    checkOutput("rd before reset cyc", {31'h0, cyc}, 32'h1);
    checkOutput("rd before reset we", {31'h0, we}, 32'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset cyc", {31'h0, cyc}, 32'h0);
    checkOutput("async reset stb", {31'h0, stb}, 32'h0);
    checkOutput("async reset rspValid", {31'h0, rspValid}, 32'h0);
    checkOutput("async reset busy", {31'h0, busy}, 32'h0);
    checkOutput("async reset cmdReady", {31'h0, cmdReady}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    extraWait = 0;
    repeat (3) @(negedge clk);
    checkOutput("post reset rspValid", {31'h0, rspValid}, 32'h0);
    checkOutput("post reset cmdReady", {31'h0, cmdReady}, 32'h1);
    checkOutput("post reset cyc", {31'h0, cyc}, 32'h0);
    runCommand(2'b10, 16'h0, 16'h0, 1'b0, 0, 0, respond(modelA, modelB, 1'b0), "postReset");

`ifdef WB_ADDSUB_INITIATOR_TIMEOUT_EN
    // Timeout: with no ack, stb stays high for 4 cycles and the command then
    // ends with an error response.
    @(negedge clk);
    mute = 1'b1;
    w0 = wrCount;
    applyStimulus(2'b00, 16'h0001, 16'h0002);
    waitValid(got, cycles, cycHigh, viol);
    checkOutput("timeout cycHigh", 32'(cycHigh), 32'd4);
    checkOutput("timeout latency", 32'(cycles), 32'd5);
    checkOutput("timeout rspErr", {31'h0, rspErr}, 32'h1);
    checkOutput("timeout rspData", rspData, 32'hDEAD_0000);
    checkOutput("timeout writes", 32'(wrCount - w0), 32'd0);
    mute = 1'b0;
    releaseRsp(1, 32'hDEAD_0000, "timeout");
`endif

    // Randomized commands checked against the command-level model.
    for (int i = 0; i < 150; i++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rsub = 1'($urandom_range(0, 1));
      case (rop)
        2'b00:   rexp = respond(ra, rb, rsub);
        2'b10:   rexp = respond(modelA, modelB, rsub);
        default: rexp = 32'h0;
      endcase
      runCommand(rop, ra, rb, rsub, $urandom_range(0, 2), $urandom_range(0, 3), rexp,
                 $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
